// File: rtl/line_fifo_reader.sv
// Read-side framer for the 8-bit FWFT line FIFO: pops bytes, frames them into lines/frames, valid/ready output.
// Optional checksum output is enabled by defining LINE_FIFO_READER_CKSUM_EN.
module line_fifo_reader #(
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 12,
    parameter int GAP_CYC = 4,
    parameter int TMO_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [LEN_W-1:0] i_line_len,
    input  logic [CNT_W-1:0] i_lines,
    input  logic [7:0]       i_fifo_dout,
    input  logic             i_fifo_empty,
    output logic             o_fifo_rd_en,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sof,
    output logic             o_eol,
    output logic             o_eof,
    output logic             o_busy,
    output logic             o_done,
`ifdef LINE_FIFO_READER_CKSUM_EN
    output logic [7:0]       o_cksum,
`endif
    output logic [1:0]       o_err
);

    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    // Timeout fires on the (2^TMO_W-1)-th consecutive stalled cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t             state_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [CNT_W-1:0]   lines_reg;
    logic [LEN_W-1:0]   byte_cnt_reg;
    logic [CNT_W-1:0]   line_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [TMO_W-1:0]   tmo_cnt_reg;
    logic [7:0]         data_reg;
    logic               valid_reg;
    logic               sof_reg;
    logic               eol_reg;
    logic               eof_reg;
    logic [1:0]         err_reg;

    logic pop;
    logic accept;
    logic last_byte;
    logic last_line;
    logic start_ok;

    assign last_byte = (byte_cnt_reg == len_reg - LEN_W'(1));
    assign last_line = (line_cnt_reg == lines_reg - CNT_W'(1));
    assign accept    = valid_reg && i_ready;
    assign start_ok  = (state_reg == IDLE) && i_start && !i_abort &&
                       (i_line_len != '0) && (i_lines != '0);

    // Abort also blocks the pop so no byte is removed from the FIFO and then discarded.
    assign pop = (state_reg == STREAM) && !i_fifo_empty && (!valid_reg || i_ready) && !i_abort;

    assign o_fifo_rd_en = pop;
    assign o_data       = data_reg;
    assign o_valid      = valid_reg;
    assign o_sof        = sof_reg;
    assign o_eol        = eol_reg;
    assign o_eof        = eof_reg;
    assign o_err        = err_reg;
    assign o_busy       = (state_reg != IDLE) || valid_reg;
    assign o_done       = accept && eof_reg && !i_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            lines_reg    <= '0;
            byte_cnt_reg <= '0;
            line_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            sof_reg      <= 1'b0;
            eol_reg      <= 1'b0;
            eof_reg      <= 1'b0;
            err_reg      <= '0;
        end else if (i_abort) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            line_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            valid_reg    <= 1'b0;
            sof_reg      <= 1'b0;
            eol_reg      <= 1'b0;
            eof_reg      <= 1'b0;
        end else begin
            // Output slot empties on acceptance; a same-cycle pop below refills it.
            if (accept) begin
                valid_reg <= 1'b0;
                sof_reg   <= 1'b0;
                eol_reg   <= 1'b0;
                eof_reg   <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        if (start_ok) begin
                            len_reg      <= i_line_len;
                            lines_reg    <= i_lines;
                            err_reg      <= '0;
                            byte_cnt_reg <= '0;
                            line_cnt_reg <= '0;
                            gap_cnt_reg  <= '0;
                            tmo_cnt_reg  <= '0;
                            state_reg    <= STREAM;
                        end else begin
                            err_reg[0] <= 1'b1;
                        end
                    end
                end

                STREAM: begin
                    if (i_start) err_reg[0] <= 1'b1;
                    if (pop) begin
                        data_reg    <= i_fifo_dout;
                        valid_reg   <= 1'b1;
                        sof_reg     <= (byte_cnt_reg == '0) && (line_cnt_reg == '0);
                        eol_reg     <= last_byte;
                        eof_reg     <= last_byte && last_line;
                        tmo_cnt_reg <= '0;
                        if (last_byte) begin
                            byte_cnt_reg <= '0;
                            if (last_line) begin
                                line_cnt_reg <= '0;
                                state_reg    <= IDLE;
                            end else begin
                                line_cnt_reg <= line_cnt_reg + CNT_W'(1);
                                if (GAP_CYC > 0) begin
                                    gap_cnt_reg <= '0;
                                    state_reg   <= GAP;
                                end
                            end
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + LEN_W'(1);
                        end
                    end else if (i_fifo_empty) begin
                        if (tmo_cnt_reg == TMO_LAST) begin
                            err_reg[1]   <= 1'b1;
                            state_reg    <= IDLE;
                            byte_cnt_reg <= '0;
                            line_cnt_reg <= '0;
                            tmo_cnt_reg  <= '0;
                        end else begin
                            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                        end
                    end
                end

                GAP: begin
                    if (i_start) err_reg[0] <= 1'b1;
                    if (gap_cnt_reg == GAP_W'(GAP_LAST)) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= STREAM;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef LINE_FIFO_READER_CKSUM_EN
    // Running sum of the current line; the presented value is refreshed with every popped byte.
    logic [7:0] cksum_acc_reg;
    logic [7:0] cksum_out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_acc_reg <= '0;
            cksum_out_reg <= '0;
        end else if (i_abort || start_ok) begin
            cksum_acc_reg <= '0;
        end else if (pop) begin
            cksum_out_reg <= cksum_acc_reg + i_fifo_dout;
            cksum_acc_reg <= last_byte ? 8'h00 : (cksum_acc_reg + i_fifo_dout);
        end
    end

    assign o_cksum = cksum_out_reg;
`endif

endmodule

// File: tb/tb_line_fifo_reader.sv
// Directed bench for line_fifo_reader: FWFT FIFO model, output logger, hand-computed expectations.
module tb_line_fifo_reader;

    localparam int LEN_W = 16;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start, i_abort, i_ready;
    logic [LEN_W-1:0] i_line_len;
    logic [CNT_W-1:0] i_lines;
    logic [7:0]       i_fifo_dout;
    logic             i_fifo_empty;
    logic             o_fifo_rd_en, o_valid, o_sof, o_eol, o_eof, o_busy, o_done;
    logic [7:0]       o_data;
    logic [1:0]       o_err;
`ifdef LINE_FIFO_READER_CKSUM_EN
    logic [7:0]       o_cksum;
`endif

    line_fifo_reader #(.LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_CYC(4), .TMO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_line_len(i_line_len), .i_lines(i_lines),
        .i_fifo_dout(i_fifo_dout), .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof), .o_busy(o_busy), .o_done(o_done),
`ifdef LINE_FIFO_READER_CKSUM_EN
        .o_cksum(o_cksum),
`endif
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [7:0] fifo_mem [0:255];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign i_fifo_empty = (rd_ptr == wr_ptr);
    assign i_fifo_dout  = fifo_mem[rd_ptr[7:0]];
    always @(posedge clk) if (o_fifo_rd_en) rd_ptr <= rd_ptr + 1;

    // Output logger and protocol watchers
    logic [10:0] log_q [$];
    int          cyc_q [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          viol_cnt = 0;
    int          hold_viol = 0;
    bit          hold_pend = 1'b0;
    logic [10:0] hold_val;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_valid && i_ready) begin
            log_q.push_back({o_sof, o_eol, o_eof, o_data});
            cyc_q.push_back(cyc);
            $display("xfer cyc=%0d data=0x%02h sof=%0b eol=%0b eof=%0b", cyc, o_data, o_sof, o_eol, o_eof);
        end
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_fifo_rd_en && (i_fifo_empty || (o_valid && !i_ready))) viol_cnt <= viol_cnt + 1;
        if (hold_pend && (!o_valid || {o_sof, o_eol, o_eof, o_data} != hold_val)) hold_viol <= hold_viol + 1;
        hold_pend <= o_valid && !i_ready && !i_abort;
        hold_val  <= {o_sof, o_eol, o_eof, o_data};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int idx);
        if (idx < log_q.size()) return {21'd0, log_q[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int cyc_at(input int idx);
        if (idx < cyc_q.size()) return cyc_q[idx];
        return -1000;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic start_frame(input int len, input int lines);
        i_line_len = LEN_W'(len);
        i_lines    = CNT_W'(lines);
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
    endtask

    // Wait for a new o_done pulse; optionally toggle i_ready each cycle.
    task automatic wait_done(input string tag, input int d0, input bit toggle);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge clk);
            if (toggle) i_ready = ~i_ready;
            k++;
        end
        i_ready = 1'b1;
        chk(tag, (done_cnt == d0) ? 32'd0 : 32'd1, 32'd1);
    endtask

    // Expected {sof,eol,eof,data} for the 2x4 frame carrying 0x10..0x17
    function automatic logic [31:0] exp_2x4(input int i);
        logic [7:0] d = 8'h10 + 8'(i);
        return {21'd0, (i == 0), (i == 3 || i == 7), (i == 7), d};
    endfunction

    initial begin
        int base, d0, rp0, k;
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b1;
        i_line_len = '0; i_lines = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_err",   o_err, 0);
        chk("rst_rd_en", o_fifo_rd_en, 0);
        chk("rst_flags", {o_sof, o_eol, o_eof, o_done, o_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2 lines of 4, ready always high
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        base = log_q.size(); d0 = done_cnt;
        start_frame(4, 2);
        wait_done("t1_done_seen", d0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_byte%0d", i), log_at(base + i), exp_2x4(i));
        chk("t1_cnt",      log_q.size() - base, 8);
        chk("t1_b2b",      cyc_at(base + 1) - cyc_at(base), 1);
        chk("t1_gap",      cyc_at(base + 4) - cyc_at(base + 3), 5);
        chk("t1_line2",    cyc_at(base + 7) - cyc_at(base + 4), 3);
        chk("t1_done_one", done_cnt - d0, 1);
        chk("t1_busy",     o_busy, 0);
        chk("t1_err",      o_err, 0);

        // Same frame with i_ready toggling
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        base = log_q.size(); d0 = done_cnt;
        i_ready = 1'b0;
        start_frame(4, 2);
        wait_done("t2_done_seen", d0, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_byte%0d", i), log_at(base + i), exp_2x4(i));
        chk("t2_cnt",  log_q.size() - base, 8);
        chk("t2_hold", hold_viol, 0);
        chk("t2_viol", viol_cnt, 0);

        // FIFO starts empty, data arrives 20 cycles later
        base = log_q.size(); d0 = done_cnt;
        start_frame(3, 1);
        rp0 = rd_ptr;
        repeat (20) @(negedge clk);
        chk("t3_busy_wait", o_busy, 1);
        chk("t3_no_pop",    rd_ptr - rp0, 0);
        push(8'h31); push(8'h32); push(8'h33);
        wait_done("t3_done_seen", d0, 1'b0);
        @(negedge clk);
        chk("t3_byte0", log_at(base),     {21'd0, 3'b100, 8'h31});
        chk("t3_byte1", log_at(base + 1), {21'd0, 3'b000, 8'h32});
        chk("t3_byte2", log_at(base + 2), {21'd0, 3'b011, 8'h33});
        chk("t3_err",   o_err, 0);
        chk("t3_viol",  viol_cnt, 0);

        // Bad starts: zero lines, then zero length
        push(8'h55);
        rp0 = rd_ptr;
        start_frame(4, 0);
        repeat (3) @(negedge clk);
        chk("t4_err_lines", o_err, 2'b01);
        chk("t4_busy",      o_busy, 0);
        chk("t4_no_pop",    rd_ptr - rp0, 0);
        start_frame(0, 2);
        @(negedge clk);
        chk("t4_err_len",   o_err, 2'b01);
        chk("t4_busy_len",  o_busy, 0);
        flush();

        // Stall timeout: 5-byte line, only 2 bytes supplied, TMO_W=5 -> 31 stalled cycles
        push(8'h41); push(8'h42);
        base = log_q.size(); d0 = done_cnt;
        start_frame(5, 1);
        k = 0;
        while (o_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5_tmo_cycles", k, 33);
        chk("t5_err",        o_err, 2'b10);
        chk("t5_no_done",    done_cnt - d0, 0);
        chk("t5_delivered",  log_q.size() - base, 2);
        chk("t5_last_byte",  log_at(base + 1), {21'd0, 3'b000, 8'h42});

        // Start while busy is flagged, then abort mid-line
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        d0 = done_cnt;
        start_frame(8, 1);
        repeat (3) @(negedge clk);
        chk("t6_err_cleared", o_err, 2'b00);
        start_frame(8, 1);
        chk("t6_err_busy_start", o_err, 2'b01);
        chk("t6_valid_mid", o_valid, 1);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("t6_valid_abort", o_valid, 0);
        chk("t6_busy_abort",  o_busy, 0);
        chk("t6_err_kept",    o_err, 2'b01);
        rp0 = rd_ptr;
        repeat (3) @(negedge clk);
        chk("t6_idle_no_pop", rd_ptr - rp0, 0);
        chk("t6_no_done",     done_cnt - d0, 0);
        flush();

`ifdef LINE_FIFO_READER_CKSUM_EN
        push(8'hFF); push(8'h02); push(8'h03);
        start_frame(3, 1);
        k = 0;
        while (!(o_valid && o_eol) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t7_eol_seen", {31'd0, o_valid && o_eol}, 1);
        chk("t7_cksum",    o_cksum, 8'h04);
        repeat (3) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
